// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: operand/store-data forwarding and load-use stall FSM; FWD_STALL_CNT_EN builds the saturating stall counter
module fwd_hazard_ctrl #(
  parameter int ADDR_W   = 4,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*ADDR_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [NUM_SRC*ADDR_W-1:0] idex_src,
  input  logic [ADDR_W-1:0]         idex_rd,
  input  logic                      idex_regwrite,
  input  logic                      idex_memread,
  input  logic [ADDR_W-1:0]         exmem_rd,
  input  logic                      exmem_regwrite,
  input  logic                      exmem_memread,
  input  logic [ADDR_W-1:0]         exmem_rt,
  input  logic                      exmem_memwrite,
  input  logic [ADDR_W-1:0]         memwb_rd,
  input  logic                      memwb_regwrite,
  input  logic                      flush,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  output logic                      fwd_mem,
  output logic                      stall,
  output logic [CNT_W-1:0]          stall_cnt
);
  typedef enum logic {IDLE, STALL} state_t;
  localparam logic [3:0] RELOAD = 4'(LOAD_LAT > 1 ? LOAD_LAT - 2 : 0);
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [NUM_SRC-1:0] use_hit;
  logic hit;
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic ex_hit, wb_hit;
    assign ex_hit = exmem_regwrite & ~exmem_memread & |exmem_rd & (exmem_rd == idex_src[i*ADDR_W +: ADDR_W]);
    assign wb_hit = memwb_regwrite & |memwb_rd & (memwb_rd == idex_src[i*ADDR_W +: ADDR_W]);
    assign fwd_sel[2*i +: 2] = ex_hit ? 2'b10 : wb_hit ? 2'b01 : 2'b00;
    assign use_hit[i] = id_src_used[i] & (id_src[i*ADDR_W +: ADDR_W] == idex_rd);
  end
  assign fwd_mem = exmem_memwrite & memwb_regwrite & |memwb_rd & (memwb_rd == exmem_rt);
  assign hit = idex_memread & idex_regwrite & |idex_rd & |use_hit;
  assign stall = ~flush & ((state == STALL) | hit);
  always_comb begin
    state_n = flush ? IDLE : (state == IDLE) ? ((hit && LOAD_LAT > 1) ? STALL : IDLE) : ((cnt == 4'd0) ? IDLE : STALL);
    cnt_n = (state == IDLE) ? RELOAD : cnt - 4'd1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 4'd0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end
`ifdef FWD_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) stall_cnt <= '0;
    else if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
  end
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: table-driven forwarding vectors plus directed stall/flush/reset/saturation sequences
module tb_fwd_hazard_ctrl;
`ifdef FWD_STALL_CNT_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  logic [7:0] id_src, idex_src;
  logic [1:0] id_src_used;
  logic [3:0] idex_rd, exmem_rd, exmem_rt, memwb_rd;
  logic idex_regwrite, idex_memread, exmem_regwrite, exmem_memread, exmem_memwrite, memwb_regwrite, flush;
  logic [3:0] fwd1, fwd3, fwds;
  logic mem1, mem3, mems, s1, s3, ss;
  logic [15:0] cnt1, cnt3;
  logic [3:0] cnts;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  fwd_hazard_ctrl #(.LOAD_LAT(1)) u1 (
    .clk(clk), .rst(rst), .id_src(id_src), .id_src_used(id_src_used), .idex_src(idex_src),
    .idex_rd(idex_rd), .idex_regwrite(idex_regwrite), .idex_memread(idex_memread),
    .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite), .exmem_memread(exmem_memread),
    .exmem_rt(exmem_rt), .exmem_memwrite(exmem_memwrite), .memwb_rd(memwb_rd),
    .memwb_regwrite(memwb_regwrite), .flush(flush), .fwd_sel(fwd1), .fwd_mem(mem1),
    .stall(s1), .stall_cnt(cnt1));
  fwd_hazard_ctrl #(.LOAD_LAT(3)) u3 (
    .clk(clk), .rst(rst), .id_src(id_src), .id_src_used(id_src_used), .idex_src(idex_src),
    .idex_rd(idex_rd), .idex_regwrite(idex_regwrite), .idex_memread(idex_memread),
    .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite), .exmem_memread(exmem_memread),
    .exmem_rt(exmem_rt), .exmem_memwrite(exmem_memwrite), .memwb_rd(memwb_rd),
    .memwb_regwrite(memwb_regwrite), .flush(flush), .fwd_sel(fwd3), .fwd_mem(mem3),
    .stall(s3), .stall_cnt(cnt3));
  fwd_hazard_ctrl #(.LOAD_LAT(1), .CNT_W(4)) us (
    .clk(clk), .rst(rst), .id_src(id_src), .id_src_used(id_src_used), .idex_src(idex_src),
    .idex_rd(idex_rd), .idex_regwrite(idex_regwrite), .idex_memread(idex_memread),
    .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite), .exmem_memread(exmem_memread),
    .exmem_rt(exmem_rt), .exmem_memwrite(exmem_memwrite), .memwb_rd(memwb_rd),
    .memwb_regwrite(memwb_regwrite), .flush(flush), .fwd_sel(fwds), .fwd_mem(mems),
    .stall(ss), .stall_cnt(cnts));
  typedef struct {
    logic [7:0] idex_src;
    logic [3:0] exmem_rd;
    logic exmem_regwrite, exmem_memread, exmem_memwrite;
    logic [3:0] exmem_rt, memwb_rd;
    logic memwb_regwrite;
    logic [3:0] exp_fwd;
    logic exp_mem;
  } vec_t;
  vec_t vecs[7];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic apply(input vec_t v);
    idex_src = v.idex_src;
    exmem_rd = v.exmem_rd;
    exmem_regwrite = v.exmem_regwrite;
    exmem_memread = v.exmem_memread;
    exmem_memwrite = v.exmem_memwrite;
    exmem_rt = v.exmem_rt;
    memwb_rd = v.memwb_rd;
    memwb_regwrite = v.memwb_regwrite;
  endtask
  task automatic set_hit(input logic on, input logic [1:0] used);
    idex_memread = on;
    idex_regwrite = on;
    idex_rd = on ? 4'd4 : 4'd0;
    id_src = 8'h04;
    id_src_used = used;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    set_hit(1'b0, 2'b00);
    flush = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    vecs[0] = '{8'h35, 4'd5, 1, 0, 0, 4'd0, 4'd5, 1, 4'b0010, 0};
    vecs[1] = '{8'h35, 4'd0, 1, 0, 0, 4'd0, 4'd5, 1, 4'b0001, 0};
    vecs[2] = '{8'h77, 4'd7, 1, 1, 1, 4'd7, 4'd7, 1, 4'b0101, 1};
    vecs[3] = '{8'h92, 4'd9, 1, 0, 1, 4'd2, 4'd2, 1, 4'b1001, 1};
    vecs[4] = '{8'h92, 4'd9, 0, 0, 1, 4'd2, 4'd2, 0, 4'b0000, 0};
    vecs[5] = '{8'h00, 4'd0, 1, 0, 1, 4'd0, 4'd0, 1, 4'b0000, 0};
    vecs[6] = '{8'h42, 4'd4, 1, 0, 0, 4'd2, 4'd2, 1, 4'b1001, 0};
    rst = 1'b1;
    flush = 1'b0;
    set_hit(1'b0, 2'b00);
    apply(vecs[0]);
    #1;
    check("fwd_during_reset", 32'(fwd1), 32'(vecs[0].exp_fwd));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_stall", 32'({s1, s3, ss}), 32'd0);
    check("reset_cnt1", 32'(cnt1), 32'd0);
    check("reset_cnt3", 32'(cnt3), 32'd0);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      apply(vecs[k]);
      #1;
      check($sformatf("fwd_sel_v%0d", k), 32'(fwd1), 32'(vecs[k].exp_fwd));
      check($sformatf("fwd_sel3_v%0d", k), 32'(fwd3), 32'(vecs[k].exp_fwd));
      check($sformatf("fwd_mem_v%0d", k), 32'(mem1), 32'(vecs[k].exp_mem));
    end
    apply('{8'h00, 4'd0, 0, 0, 0, 4'd0, 4'd0, 0, 4'b0000, 0});
    @(negedge clk);
    set_hit(1'b1, 2'b01);
    #1;
    check("lu_c0_lat1", 32'(s1), 32'd1);
    check("lu_c0_lat3", 32'(s3), 32'd1);
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      set_hit(1'b0, 2'b00);
      #1;
      check($sformatf("lu_c%0d_lat1", k), 32'(s1), 32'd0);
      check($sformatf("lu_c%0d_lat3", k), 32'(s3), (k < 3) ? 32'd1 : 32'd0);
    end
    check("lu_cnt_lat1", 32'(cnt1), EN ? 32'd1 : 32'd0);
    check("lu_cnt_lat3", 32'(cnt3), EN ? 32'd3 : 32'd0);
    @(negedge clk);
    set_hit(1'b1, 2'b10);
    #1;
    check("unused_lat1", 32'(s1), 32'd0);
    check("unused_lat3", 32'(s3), 32'd0);
    @(negedge clk);
    #1;
    check("unused_lat3_c1", 32'(s3), 32'd0);
    check("unused_cnt3", 32'(cnt3), EN ? 32'd3 : 32'd0);
    do_reset();
    @(negedge clk);
    set_hit(1'b1, 2'b01);
    #1;
    check("flush_c0", 32'(s3), 32'd1);
    @(negedge clk);
    set_hit(1'b0, 2'b00);
    flush = 1'b1;
    #1;
    check("flush_c1", 32'(s3), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_c2_idle", 32'(s3), 32'd0);
    @(negedge clk);
    #1;
    check("flush_c3_idle", 32'(s3), 32'd0);
    check("flush_cnt3", 32'(cnt3), EN ? 32'd1 : 32'd0);
    @(negedge clk);
    set_hit(1'b1, 2'b01);
    flush = 1'b1;
    #1;
    check("flush_and_hit", 32'({s1, s3}), 32'd0);
    @(negedge clk);
    set_hit(1'b0, 2'b00);
    flush = 1'b0;
    #1;
    check("flush_and_hit_next", 32'(s3), 32'd0);
    do_reset();
    @(negedge clk);
    set_hit(1'b1, 2'b01);
    #1;
    check("rst_c0", 32'(s3), 32'd1);
    @(negedge clk);
    set_hit(1'b0, 2'b00);
    rst = 1'b1;
    #1;
    check("rst_c1", 32'(s3), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_c2_stall", 32'(s3), 32'd0);
    check("rst_c2_cnt", 32'(cnt3), 32'd0);
    do_reset();
    @(negedge clk);
    set_hit(1'b1, 2'b01);
    for (int k = 0; k < 10; k++) @(negedge clk);
    #1;
    check("sat_mid", 32'(cnts), EN ? 32'd10 : 32'd0);
    for (int k = 0; k < 10; k++) @(negedge clk);
    set_hit(1'b0, 2'b00);
    #1;
    check("sat_end", 32'(cnts), EN ? 32'd15 : 32'd0);
    check("sat_wide_cnt", 32'(cnt1), EN ? 32'd20 : 32'd0);
    @(negedge clk);
    #1;
    check("sat_hold", 32'(cnts), EN ? 32'd15 : 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Parametrised forwarding and hazard controller for the pipelined core. It generalises the existing EX-EX / MEM-EX / MEM-MEM forwarding logic to NUM_SRC source operands. It adds load-use hazard detection with a multi-cycle stall state machine (LOAD_LAT cycles), branch-flush cancellation, and an optional saturating stall counter. It sits beside the ID/EX stage, drives the EX operand muxes and MEM store-data mux, and holds PC/IF-ID while inserting bubbles into ID/EX.

## Interface
- ADDR_W, 4, register address width; register 0 is hardwired zero.
- NUM_SRC, 2, source operands per instruction.
- LOAD_LAT, 1, stall cycles per load-use hazard; range 1..15.
- CNT_W, 16, stall counter width.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_src  in  NUM_SRC*ADDR_W  source regs of instruction in ID; operand i at [i*ADDR_W +: ADDR_W].
- id_src_used  in  NUM_SRC  operand i is actually read.
- idex_src  in  NUM_SRC*ADDR_W  source regs of instruction in EX.
- idex_rd, idex_regwrite, idex_memread  in  ADDR_W/1/1  EX-stage destination, write enable, load flag.
- exmem_rd, exmem_regwrite, exmem_memread  in  ADDR_W/1/1  MEM-stage destination, write enable, load flag.
- exmem_rt  in  ADDR_W  store-data source reg of the instruction in MEM.
- exmem_memwrite  in  1  MEM instruction is a store.
- memwb_rd, memwb_regwrite  in  ADDR_W/1  WB-stage destination and write enable.
- flush  in  1  branch/jump flush from EX.
- fwd_sel  out  2*NUM_SRC  per operand: 00 register file, 10 EX/MEM, 01 MEM/WB.
- fwd_mem  out  1  select MEM/WB result as store data.
- stall  out  1  hold PC and IF/ID, bubble ID/EX.
- stall_cnt  out  CNT_W  cycles with stall=1.

## Operation
- Forwarding is combinational, per operand i:
  - ex_hit = exmem_regwrite & ~exmem_memread & exmem_rd!=0 & exmem_rd==idex_src[i].
  - wb_hit = memwb_regwrite & memwb_rd!=0 & memwb_rd==idex_src[i].
  - fwd_sel[i] = ex_hit ? 10 : wb_hit ? 01 : 00. EX/MEM always wins over MEM/WB.
- A load in MEM never forwards from EX/MEM. Its data reaches EX only via MEM/WB.
- fwd_mem = exmem_memwrite & memwb_regwrite & memwb_rd!=0 & memwb_rd==exmem_rt.
- Load-use hit: idex_memread & idex_regwrite & idex_rd!=0 & some i with id_src_used[i] & id_src[i]==idex_rd.
- FSM states:
  - IDLE:
    - hit & ~flush: stall=1.
    - If LOAD_LAT>1, load cnt=LOAD_LAT-2 and go to STALL.
    - Otherwise stay in IDLE. This is the classic single bubble.
  - STALL: stall=1.
    - cnt==0: next state is IDLE.
    - Otherwise decrement cnt.
    - Hits are ignored while in STALL.
- flush has priority in every state: stall=0 in the same cycle, and next state is IDLE.
- The stall output is combinational from state, hit and flush. Each load-use hazard produces exactly LOAD_LAT consecutive stall cycles unless flushed.

## Timing
- Forward outputs: zero latency, no registered state. They are valid during reset too.
- Reset: state=IDLE, cnt=0, stall_cnt=0.
- stall asserts in the same cycle the hit appears in ID/EX vs ID. It deasserts in the cycle after the last stall cycle.
- After the stall window ends in IDLE, the held instruction re-evaluates. The load has moved to MEM, so no hit recurs and the MEM/WB forward follows one cycle later.
- rst mid-stall: next cycle state is IDLE and stall=0.
- flush and hit in the same cycle: stall=0.
- stall_cnt increments on every cycle where stall=1 and saturates at all-ones.

## Configuration
- FWD_STALL_CNT_EN defined: stall_cnt is a CNT_W-bit saturating counter as specified above.
- FWD_STALL_CNT_EN undefined: the counter is not built and stall_cnt is tied to 0.
- Forwarding and stall behaviour is identical in both builds.

## Test plan
- Double match: exmem_rd=5, memwb_rd=5 (both regwrite), idex_src[0]=5, idex_src[1]=3 -> fwd_sel[1:0]=10, fwd_sel[3:2]=00. Same with exmem_rd=0 -> fwd_sel[1:0]=01.
- Load forwarding: exmem_memread=1, exmem_rd=7, memwb_rd=7, idex_src[0]=7 -> fwd_sel[1:0]=01. Store case: exmem_memwrite=1, exmem_rt=7 -> fwd_mem=1.
- Load-use with LOAD_LAT=1: load to r4 in EX, ID reads r4 -> stall high exactly 1 cycle, stall_cnt=1. Same with id_src_used=0 -> no stall.
- Multi-cycle load-use with LOAD_LAT=3: same stimulus -> stall high 3 consecutive cycles, then 0. stall_cnt=3 when FWD_STALL_CNT_EN is defined, 0 otherwise.
- Interruptions with LOAD_LAT=3:
  - flush in the 2nd stall cycle -> stall=0 that cycle, IDLE next.
  - rst in the 2nd stall cycle -> stall=0 the next cycle, stall_cnt=0.
- Saturation: CNT_W=4 with 20 stall cycles -> stall_cnt holds 15.
